// File: rtl/ioctl_sdram_loader.sv
// ioctl download -> byte-wide sdram write sequencer with CPU bus passthrough.
// Ports: clk_sys/reset (sync, active-high); ioctl_* download stream in;
// cpu_* SRAM-style bus in; ram_ready in; ram_addr/ram_din/ram_we/ram_rd out;
// cpu_wait, load_done (pulse), overflow (sticky) out.
// Optional: define LOADER_CSUM_EN to add csum[7:0] (sum of written bytes).
module ioctl_sdram_loader #(
  parameter int unsigned       ADDR_W     = 23,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_we_n,
  input  logic              cpu_oe_n,
  input  logic              ram_ready,
`ifdef LOADER_CSUM_EN
  output logic [7:0]        csum,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic              ram_rd,
  output logic              cpu_wait,
  output logic              load_done,
  output logic              overflow
);

  localparam int unsigned PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_FLUSH, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              dl_q, dl_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic              load_done_q, load_done_d;
  logic              overflow_q, overflow_d;
`ifdef LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [ADDR_W+7:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W+7:0] head;

  logic rise, push, pop, full, empty, accept;

  always_comb begin
    rise   = ioctl_download & ~dl_q;
    push   = ioctl_download & ioctl_wr;
    pop    = (state_q == S_WRITE) & ram_we_q & ram_ready;
    full   = (cnt_q == FULL_CNT);
    empty  = (cnt_q == '0);
    // A full FIFO still takes the byte when the head leaves this cycle.
    accept = push & (~full | pop);
    head   = mem_q[rd_ptr_q];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (rise) state_d = S_LOAD;
      S_LOAD: begin
        if (!empty)               state_d = S_WRITE;
        else if (!ioctl_download) state_d = S_FLUSH;
      end
      S_WRITE: if (pop) state_d = S_LOAD;
      S_FLUSH: begin
        if (ioctl_download) state_d = S_LOAD;
        else if (!empty)    state_d = S_WRITE;
        else                state_d = S_DONE;
      end
      S_DONE:  state_d = rise ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dl_d     = ioctl_download;
    wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;

    ram_we_d    = (state_d == S_WRITE);
    load_done_d = (state_d == S_DONE);

    // Latch the FIFO head only on entry to WRITE.
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (state_q != S_WRITE && state_d == S_WRITE) begin
      ram_addr_d = head[ADDR_W+7:8];
      ram_din_d  = head[7:0];
    end

    overflow_d = rise ? 1'b0 : overflow_q;
    if (push && !accept) overflow_d = 1'b1;

`ifdef LOADER_CSUM_EN
    csum_d = rise ? 8'h00 : csum_q;
    if (pop) csum_d = csum_d + ram_din_q;
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (accept)
      mem_q[wr_ptr_q] <= {ioctl_addr + BASE_ADDR, ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      dl_q        <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      dl_q        <= dl_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      load_done_q <= load_done_d;
      overflow_q  <= overflow_d;
`ifdef LOADER_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // DONE already releases the CPU so cpu_wait falls with the load_done pulse.
  always_comb begin
    cpu_wait  = (state_q != S_IDLE) && (state_q != S_DONE);
    load_done = load_done_q;
    overflow  = overflow_q;
    if (state_q == S_IDLE) begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = ~cpu_we_n;
      ram_rd   = ~cpu_oe_n;
    end else begin
      ram_addr = ram_addr_q;
      ram_din  = ram_din_q;
      ram_we   = ram_we_q;
      ram_rd   = 1'b0;
    end
`ifdef LOADER_CSUM_EN
    csum = csum_q;
`endif
  end

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader.
// BASE_ADDR sits near the top of the space so every load exercises wrap.
module tb_ioctl_sdram_loader;

  localparam logic [22:0] BASE = 23'h7FFFFE;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [22:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [22:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we_n;
  logic        cpu_oe_n;
  logic        ram_ready;
  logic [22:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        ram_rd;
  logic        cpu_wait;
  logic        load_done;
  logic        overflow;
`ifdef LOADER_CSUM_EN
  logic [7:0]  csum;
  logic [7:0]  csum_done;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_wait = 0;
  logic auto_rdy = 1'b0;
  logic [30:0] wq[$];

  ioctl_sdram_loader #(
    .ADDR_W(23), .FIFO_DEPTH(4), .BASE_ADDR(BASE)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_we_n(cpu_we_n), .cpu_oe_n(cpu_oe_n),
    .ram_ready(ram_ready),
`ifdef LOADER_CSUM_EN
    .csum(csum),
`endif
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_rd(ram_rd),
    .cpu_wait(cpu_wait), .load_done(load_done),
    .overflow(overflow)
  );

  initial forever #20 clk_sys = ~clk_sys;

  // sdram model: acknowledge one cycle after a loader write appears
  initial begin
    ram_ready = 1'b0;
    forever begin
      @(posedge clk_sys);
      #2;
      ram_ready = auto_rdy && cpu_wait && ram_we;
    end
  end

  always @(negedge clk_sys) begin
    if (cpu_wait && ram_we && ram_ready)
      wq.push_back({ram_addr, ram_din});
    if (load_done) begin
      done_cnt = done_cnt + 1;
      if (cpu_wait) done_wait = done_wait + 1;
`ifdef LOADER_CSUM_EN
      csum_done = csum;
`endif
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [22:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev);
    for (int i = 0; i < 200 && done_cnt == prev; i++) tick();
    chk(tag, done_cnt, prev + 1);
  endtask

  task automatic exp_w(input string tag, input int idx,
                       input logic [22:0] a, input logic [7:0] d);
    logic [30:0] got;
    got = (idx < wq.size()) ? wq[idx] : 31'h7FFFFFFF;
    chk(tag, {1'b0, got}, {1'b0, a, d});
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    cpu_addr = '0;
    cpu_din = '0;
    cpu_we_n = 1'b1;
    cpu_oe_n = 1'b1;
    tick();
    tick();
    chk("rst_wait", cpu_wait, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_rd", ram_rd, 0);
    chk("rst_done", load_done, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick();

    // passthrough
    cpu_addr = 23'h1234;
    cpu_din  = 8'hA5;
    cpu_we_n = 1'b0;
    #1;
    chk("pt_addr", ram_addr, 23'h1234);
    chk("pt_we", ram_we, 1);
    chk("pt_din", ram_din, 8'hA5);
    chk("pt_wait", cpu_wait, 0);
    cpu_we_n = 1'b1;
    cpu_oe_n = 1'b0;
    #1;
    chk("pt_rd", ram_rd, 1);
    cpu_oe_n = 1'b1;
    tick();

    // four-byte download with prompt acks
    auto_rdy = 1'b1;
    wq.delete();
    d0 = done_cnt;
    ioctl_download = 1'b1;
    tick();
    chk("dl_wait", cpu_wait, 1);
    send(23'd0, 8'h11);
    chk("lat1", ram_we, 0);
    tick();
    chk("lat2", ram_we, 1);
    chk("lat2_rd", ram_rd, 0);
    repeat (3) tick();
    send(23'd1, 8'h22);
    repeat (4) tick();
    send(23'd2, 8'h33);
    repeat (4) tick();
    send(23'd3, 8'h44);
    repeat (4) tick();
    ioctl_download = 1'b0;
    wait_done("dl_done", d0);
    tick();
    chk("dl_n", wq.size(), 4);
    exp_w("dl_w0", 0, 23'h7FFFFE, 8'h11);
    exp_w("dl_w1", 1, 23'h7FFFFF, 8'h22);
    exp_w("dl_w2", 2, 23'h000000, 8'h33);
    exp_w("wrap", 3, 23'h000001, 8'h44);
    chk("dl_once", done_cnt, d0 + 1);
    chk("done_wait", done_wait, 0);
    chk("dl_end_wait", cpu_wait, 0);
`ifdef LOADER_CSUM_EN
    chk("csum_a", csum_done, 8'hAA);
`endif

    // overflow: sdram stalled, six back-to-back bytes into depth 4
    auto_rdy = 1'b0;
    wq.delete();
    d0 = done_cnt;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) send(23'(i), 8'(8'h60 + i));
    chk("ovf_set", overflow, 1);
    repeat (14) tick();
    chk("ovf_stall", wq.size(), 0);
    auto_rdy = 1'b1;
    ioctl_download = 1'b0;
    wait_done("ovf_done", d0);
    tick();
    chk("ovf_n", wq.size(), 4);
    exp_w("ovf_w0", 0, 23'h7FFFFE, 8'h60);
    exp_w("ovf_w3", 3, 23'h000001, 8'h63);
    chk("ovf_sticky", overflow, 1);

    // reset while a write is pending with bytes queued
    auto_rdy = 1'b0;
    wq.delete();
    d0 = done_cnt;
    ioctl_download = 1'b1;
    tick();
    chk("ovf_clr", overflow, 0);
    send(23'd8, 8'hA1);
    send(23'd9, 8'hA2);
    send(23'd10, 8'hA3);
    tick();
    chk("mid_we", ram_we, 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    chk("rw_we", ram_we, 0);
    chk("rw_wait", cpu_wait, 0);
    reset = 1'b0;
    auto_rdy = 1'b1;
    repeat (12) tick();
    chk("rw_nodone", done_cnt, d0);
    chk("rw_nowr", wq.size(), 0);

    // last byte coincides with the download falling
    wq.delete();
    d0 = done_cnt;
    ioctl_download = 1'b1;
    tick();
    send(23'd4, 8'hFF);
    send(23'd5, 8'h02);
    ioctl_download = 1'b0;
    wait_done("fl_done", d0);
    tick();
    chk("fl_n", wq.size(), 2);
    exp_w("fl_w0", 0, 23'h000002, 8'hFF);
    exp_w("fl_w1", 1, 23'h000003, 8'h02);
`ifdef LOADER_CSUM_EN
    chk("csum_b", csum_done, 8'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
